// File: rtl/display_arbiter.sv
// Round-robin owner selection for the shared 4-digit seven-segment display.
// Each owner is held for at least HOLD_CYCLES before a waiting requester may take over.
module display_arbiter #(
   parameter int          NUM_REQ     = 4,
   parameter int          HOLD_CYCLES = 100000000,
   parameter logic [3:0]  IDLE_BCD    = 4'd0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [16*NUM_REQ-1:0]   data,
   output logic [NUM_REQ-1:0]      grant,
   output logic                    active,
   output logic [3:0]              bcd3,
   output logic [3:0]              bcd2,
   output logic [3:0]              bcd1,
   output logic [3:0]              bcd0
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam int               CNT_W    = $clog2(HOLD_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [15:0]      IDLE_ALL = {4{IDLE_BCD}};

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   state_t               state_q,  state_d;
   logic [NUM_REQ-1:0]   grant_q,  grant_d;
   logic                 active_q, active_d;
   logic [15:0]          bcd_q,    bcd_d;
   logic [IDX_W-1:0]     ptr_q,    ptr_d;
   logic [IDX_W-1:0]     owner_q,  owner_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;

   logic [IDX_W:0]       pick_new;
   logic [IDX_W:0]       pick_next;
   logic                 owner_req;
   logic                 take;
   logic [IDX_W-1:0]     sel;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return IDX_W'((int'(i) + 1) % NUM_REQ);
   endfunction

   // Returns {found, index}; scanning from the far end lets the nearest set bit win.
   function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] start,
                                              input logic [NUM_REQ-1:0] mask);
      logic [IDX_W:0]   res;
      logic [IDX_W-1:0] i_w;
      res = '0;
      for (int d = NUM_REQ - 1; d >= 0; d--) begin
         i_w = IDX_W'((int'(start) + d) % NUM_REQ);
         if (mask[i_w]) res = {1'b1, i_w};
      end
      return res;
   endfunction

   function automatic logic [15:0] slice_of(input logic [IDX_W-1:0] s,
                                            input logic [16*NUM_REQ-1:0] d);
      logic [15:0] res;
      res = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == s) res = d[16*i +: 16];
      end
      return res;
   endfunction

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      active_d  = active_q;
      bcd_d     = bcd_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      take      = 1'b0;
      sel       = '0;
      owner_req = |(req & grant_q);
      pick_new  = rr_pick(ptr_q, req);
      // The owner is masked out, so release and preemption share one search.
      pick_next = rr_pick(next_idx(owner_q), req & ~grant_q);

      case (state_q)
         S_IDLE: begin
            if (pick_new[IDX_W]) begin
               take = 1'b1;
               sel  = pick_new[IDX_W-1:0];
            end
         end
         S_OWNED: begin
            if ((!owner_req || cnt_q == CNT_MAX) && pick_next[IDX_W]) begin
               take = 1'b1;
               sel  = pick_next[IDX_W-1:0];
            end else if (!owner_req) begin
               state_d  = S_IDLE;
               grant_d  = '0;
               active_d = 1'b0;
               bcd_d    = IDLE_ALL;
               cnt_d    = '0;
            end else begin
               bcd_d = slice_of(owner_q, data);
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take) begin
         state_d  = S_OWNED;
         grant_d  = NUM_REQ'(1) << sel;
         active_d = 1'b1;
         bcd_d    = slice_of(sel, data);
         owner_d  = sel;
         ptr_d    = next_idx(sel);
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         active_q <= 1'b0;
         bcd_q    <= IDLE_ALL;
         ptr_q    <= '0;
         owner_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         active_q <= active_d;
         bcd_q    <= bcd_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
      end
   end

   assign grant  = grant_q;
   assign active = active_q;
   assign bcd3   = bcd_q[15:12];
   assign bcd2   = bcd_q[11:8];
   assign bcd1   = bcd_q[7:4];
   assign bcd0   = bcd_q[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_REQ=4, HOLD_CYCLES=8, IDLE_BCD=0.
module tb_display_arbiter;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   logic [3:0]  req     = '0;
   logic [63:0] data    = '0;
   logic [3:0]  grant;
   logic        active;
   logic [3:0]  bcd3, bcd2, bcd1, bcd0;
   logic [15:0] disp;
   int          checks   = 0;
   int          failures = 0;

   logic [15:0] rr_bcd [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
   logic [3:0]  rr_gnt [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   assign disp = {bcd3, bcd2, bcd1, bcd0};

   display_arbiter #(
      .NUM_REQ     (4),
      .HOLD_CYCLES (8),
      .IDLE_BCD    (4'd0)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .req     (req),
      .data    (data),
      .grant   (grant),
      .active  (active),
      .bcd3    (bcd3),
      .bcd2    (bcd2),
      .bcd1    (bcd1),
      .bcd0    (bcd0)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset takes effect before any clock edge
      #2 reset_n = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_active", 32'(active), 32'h0);
      chk("rst_bcd", 32'(disp), 32'h0);
      step();
      step();
      reset_n = 1'b1;
      step();
      step();
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_bcd", 32'(disp), 32'h0);

      // Single requester, data follows with one edge of latency
      req = 4'b0001;
      data[15:0] = 16'h1234;
      step();
      chk("own0_grant", 32'(grant), 32'h1);
      chk("own0_active", 32'(active), 32'h1);
      chk("own0_bcd", 32'(disp), 32'h1234);
      data[15:0] = 16'h5678;
      step();
      chk("own0_bcd_upd", 32'(disp), 32'h5678);

      // Req 2 arrives 2 cycles in; owner 0 keeps the display for 8 owned cycles
      req = 4'b0101;
      data[47:32] = 16'h9abc;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("hold_grant", 32'(grant), 32'h1);
      end
      step();
      chk("preempt_grant", 32'(grant), 32'h4);
      chk("preempt_bcd", 32'(disp), 32'h9abc);

      // Release to idle, then handover without an idle cycle
      req = 4'b0000;
      step();
      chk("rel_grant", 32'(grant), 32'h0);
      chk("rel_active", 32'(active), 32'h0);
      chk("rel_bcd", 32'(disp), 32'h0);
      req = 4'b0010;
      data[31:16] = 16'h2468;
      step();
      chk("own1_grant", 32'(grant), 32'h2);
      chk("own1_bcd", 32'(disp), 32'h2468);
      req = 4'b1000;
      data[63:48] = 16'h1357;
      step();
      chk("handover_grant", 32'(grant), 32'h8);
      chk("handover_active", 32'(active), 32'h1);
      chk("handover_bcd", 32'(disp), 32'h1357);
      req = 4'b0100;
      step();
      chk("own2_grant", 32'(grant), 32'h4);

      // Async reset between edges; pointer returns to 0 so requester 1 beats 3
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_grant", 32'(grant), 32'h0);
      chk("mid_rst_active", 32'(active), 32'h0);
      chk("mid_rst_bcd", 32'(disp), 32'h0);
      req = 4'b1010;
      #1 reset_n = 1'b1;
      step();
      chk("post_rst_grant", 32'(grant), 32'h2);
      chk("post_rst_bcd", 32'(disp), 32'h2468);

      // All four requesting: rotate 0,1,2,3,0 with 8 cycles each
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      req = 4'b1111;
      step();
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 8; c++) begin
            chk("rr_grant", 32'(grant), 32'(rr_gnt[k % 4]));
            if (c == 0) chk("rr_bcd", 32'(disp), 32'(rr_bcd[k % 4]));
            step();
         end
      end
      chk("rr_wrap_grant", 32'(grant), 32'h2);

      // Lone owner keeps the display with a saturated counter, then yields at once
      req = 4'b0010;
      repeat (20) step();
      chk("sat_grant", 32'(grant), 32'h2);
      chk("sat_bcd", 32'(disp), 32'h2222);
      req = 4'b1010;
      step();
      chk("sat_preempt_grant", 32'(grant), 32'h8);
      chk("sat_preempt_bcd", 32'(disp), 32'h4444);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
